// File: rtl/bht_predictor.sv
`default_nettype none
// ============================================================================
// Module   : bht_predictor
// Purpose  : Bimodal branch predictor (2-bit counters) with an in-order
//            in-flight FIFO; optional gshare indexing via BHT_GSHARE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bht_predictor #(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 6,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       pred_valid,
    input  logic [PC_WIDTH-1:0]        pred_pc,
    output logic                       pred_ready,
    output logic                       pred_out_valid,
    output logic                       pred_out_taken,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       success,
    output logic                       res_err,
    output logic [$clog2(DEPTH):0]     inflight
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            r_table     [c_ENTRIES];
    logic [INDEX_BITS-1:0] r_fifo_idx  [DEPTH];
    logic                  r_fifo_pred [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_pred_out_valid;
    logic                  r_pred_out_taken;
    logic                  r_success;
    logic                  r_res_err;

    logic [INDEX_BITS-1:0] w_idx;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_err;
    logic                  w_lookup;
    logic [INDEX_BITS-1:0] w_head_idx;
    logic                  w_head_pred;
    logic [1:0]            w_head_ctr;
    logic [1:0]            w_ctr_next;

`ifdef BHT_GSHARE_EN
    logic [INDEX_BITS-1:0] r_ghr;

    assign w_idx = pred_pc[INDEX_BITS+1:2] ^ r_ghr;

    // History advances only on retired (non-flushed) resolves
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ghr <= '0;
        end else if (w_pop) begin
            r_ghr <= {r_ghr[INDEX_BITS-2:0], res_taken};
        end
    end
`else
    assign w_idx = pred_pc[INDEX_BITS+1:2];
`endif

    assign w_full   = (r_count == c_CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_pop    = res_valid & ~flush & ~w_empty;
    assign w_err    = res_valid & ~flush & w_empty;
    // A push into a full FIFO is tolerated when the same cycle retires the head
    assign w_push   = pred_valid & ~flush & (~w_full | w_pop);
    assign w_lookup = r_table[w_idx][1];

    assign w_head_idx  = r_fifo_idx[r_rd_ptr];
    assign w_head_pred = r_fifo_pred[r_rd_ptr];
    assign w_head_ctr  = r_table[w_head_idx];

    always_comb begin
        w_ctr_next = w_head_ctr;
        if (res_taken) begin
            if (w_head_ctr != 2'b11) begin
                w_ctr_next = w_head_ctr + 2'd1;
            end
        end else begin
            if (w_head_ctr != 2'b00) begin
                w_ctr_next = w_head_ctr - 2'd1;
            end
        end
    end

    // Counter table: lookup above sees the pre-update value in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_table[i] <= 2'b01;
            end
        end else if (w_pop) begin
            r_table[w_head_idx] <= w_ctr_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_idx[i]  <= '0;
                r_fifo_pred[i] <= 1'b0;
            end
        end else if (w_push) begin
            r_fifo_idx[r_wr_ptr]  <= w_idx;
            r_fifo_pred[r_wr_ptr] <= w_lookup;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pred_out_valid <= 1'b0;
            r_pred_out_taken <= 1'b0;
            r_success        <= 1'b1;
            r_res_err        <= 1'b0;
        end else begin
            r_pred_out_valid <= w_push;
            r_pred_out_taken <= w_push & w_lookup;
            r_success        <= ~w_pop | (w_head_pred == res_taken);
            r_res_err        <= w_err;
        end
    end

    assign pred_ready     = ~w_full;
    assign pred_out_valid = r_pred_out_valid;
    assign pred_out_taken = r_pred_out_taken;
    assign success        = r_success;
    assign res_err        = r_res_err;
    assign inflight       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_bht_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_bht_predictor
// Purpose  : Directed self-checking bench for bht_predictor with a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bht_predictor;

    localparam int PC_WIDTH   = 32;
    localparam int INDEX_BITS = 6;
    localparam int DEPTH      = 4;
    localparam int ENTRIES    = 1 << INDEX_BITS;

    logic                clk;
    logic                reset;
    logic                flush;
    logic                pred_valid;
    logic [PC_WIDTH-1:0] pred_pc;
    logic                pred_ready;
    logic                pred_out_valid;
    logic                pred_out_taken;
    logic                res_valid;
    logic                res_taken;
    logic                success;
    logic                res_err;
    logic [2:0]          inflight;

    bht_predictor #(
        .PC_WIDTH   (PC_WIDTH),
        .INDEX_BITS (INDEX_BITS),
        .DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_ready     (pred_ready),
        .pred_out_valid (pred_out_valid),
        .pred_out_taken (pred_out_taken),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .success        (success),
        .res_err        (res_err),
        .inflight       (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Behavioural model: counters as ints, in-flight branches as a queue
    typedef struct {
        int idx;
        bit pred;
    } ent_t;

    ent_t q[$];
    int   tbl[ENTRIES];
    int   ghr;
    int   exp_valid, exp_taken, exp_success, exp_err, exp_inflight;
    int   m_idx;
    bit   m_pop, m_push, m_pred;
    ent_t m_head;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) tbl[i] = 1;
            q.delete();
            ghr          = 0;
            exp_valid    = 0;
            exp_taken    = 0;
            exp_success  = 1;
            exp_err      = 0;
            exp_inflight = 0;
        end else begin
            m_pop  = res_valid && !flush && (q.size() != 0);
            m_push = pred_valid && !flush && ((q.size() < DEPTH) || m_pop);
            m_idx  = int'((pred_pc >> 2) & 32'h3F);
`ifdef BHT_GSHARE_EN
            m_idx  = m_idx ^ ghr;
`endif
            m_pred       = (tbl[m_idx] >= 2);
            exp_valid    = m_push;
            exp_taken    = m_push && m_pred;
            exp_err      = res_valid && !flush && (q.size() == 0);
            exp_success  = 1;
            if (m_pop) begin
                m_head      = q.pop_front();
                exp_success = (m_head.pred == res_taken);
                if (res_taken) tbl[m_head.idx] = (tbl[m_head.idx] == 3) ? 3 : tbl[m_head.idx] + 1;
                else           tbl[m_head.idx] = (tbl[m_head.idx] == 0) ? 0 : tbl[m_head.idx] - 1;
                ghr = ((ghr << 1) | int'(res_taken)) & (ENTRIES - 1);
            end
            if (m_push) q.push_back('{idx: m_idx, pred: m_pred});
            if (flush) q.delete();
            exp_inflight = q.size();
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("pred_out_valid", int'(pred_out_valid), exp_valid);
            chk("pred_out_taken", int'(pred_out_taken), exp_taken);
            chk("success",        int'(success),        exp_success);
            chk("res_err",        int'(res_err),        exp_err);
            chk("inflight",       int'(inflight),       exp_inflight);
            chk("pred_ready",     int'(pred_ready),     int'(exp_inflight != DEPTH));
        end
    end

    task automatic cyc(input bit pv, input logic [31:0] pc, input bit rv, input bit rt, input bit fl);
        pred_valid = pv;
        pred_pc    = pc;
        res_valid  = rv;
        res_taken  = rt;
        flush      = fl;
        @(negedge clk);
        #1;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        res_taken  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_inflight",   int'(inflight),       0);
        chk("rst_pred_ready", int'(pred_ready),     1);
        chk("rst_success",    int'(success),        1);
        chk("rst_out_valid",  int'(pred_out_valid), 0);
        chk("rst_res_err",    int'(res_err),        0);
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        flush      = 1'b0;
        pred_valid = 1'b0;
        pred_pc    = '0;
        res_valid  = 1'b0;
        res_taken  = 1'b0;
        do_reset();
        started = 1;

        // First predict from reset state: weakly not-taken
        cyc(1, 32'h40, 0, 0, 0);
        chk("p1_valid", int'(pred_out_valid), 1);
        chk("p1_taken", int'(pred_out_taken), 0);
        chk("p1_inflight", int'(inflight), 1);
        cyc(0, 0, 1, 1, 0);
        chk("r1_success", int'(success), 0);
        cyc(1, 32'h40, 0, 0, 0);
        chk("p2_taken", int'(pred_out_taken), 1);
        chk("p2_success_back", int'(success), 1);
        cyc(0, 0, 1, 1, 0);
        chk("r2_success", int'(success), 1);
        cyc(1, 32'h43, 0, 0, 0);
        chk("p3_taken", int'(pred_out_taken), 1);
        cyc(0, 0, 1, 1, 0);
        chk("r3_success", int'(success), 1);

        // Fill to DEPTH, then a dropped request, then drain one
        for (int i = 0; i < DEPTH; i++) cyc(1, 32'(i * 4), 0, 0, 0);
        chk("full_ready", int'(pred_ready), 0);
        chk("full_inflight", int'(inflight), 4);
        cyc(1, 32'h8, 0, 0, 0);
        chk("drop_valid", int'(pred_out_valid), 0);
        cyc(0, 0, 1, 0, 0);
        chk("drain_ready", int'(pred_ready), 1);
        chk("drain_success", int'(success), 1);

        // Refill, then predict + resolve together on a full FIFO
        cyc(1, 32'h40, 0, 0, 0);
        cyc(1, 32'h40, 1, 1, 0);
        chk("sim_inflight", int'(inflight), 4);
        chk("sim_valid", int'(pred_out_valid), 1);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 32'h4, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 0, 0);
        chk("drained", int'(inflight), 0);

        // Resolve with nothing in flight
        cyc(0, 0, 1, 0, 0);
        chk("err_pulse", int'(res_err), 1);
        chk("err_success", int'(success), 1);
        cyc(0, 0, 0, 0, 0);
        chk("err_clear", int'(res_err), 0);
        cyc(1, 32'h40, 0, 0, 0);
        chk("err_tbl_same", int'(pred_out_taken), 1);
        cyc(0, 0, 1, 1, 0);

        // Saturation at zero on index 0
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'h0, 0, 0, 0);
            cyc(0, 0, 1, 0, 0);
        end
        cyc(1, 32'h0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(1, 32'h0, 0, 0, 0);
        chk("sat0_taken", int'(pred_out_taken), 0);
        cyc(0, 0, 1, 0, 0);

        // Flush alongside a resolve and a predict
        cyc(1, 32'h80, 0, 0, 0);
        cyc(1, 32'h80, 0, 0, 0);
        cyc(1, 32'h80, 1, 1, 1);
        chk("fl_inflight", int'(inflight), 0);
        chk("fl_success", int'(success), 1);
        chk("fl_valid", int'(pred_out_valid), 0);
        cyc(1, 32'h80, 0, 0, 0);
        chk("fl_tbl_kept", int'(pred_out_taken), 0);
        cyc(0, 0, 1, 1, 0);
        cyc(1, 32'h80, 0, 0, 0);
        chk("fl_trained", int'(pred_out_taken), 1);
        cyc(0, 0, 1, 1, 0);

        // Asynchronous reset mid-operation
        cyc(1, 32'h40, 0, 0, 0);
        cyc(1, 32'h44, 0, 0, 0);
        do_reset();
        cyc(1, 32'h40, 0, 0, 0);
        chk("postrst_taken", int'(pred_out_taken), 0);
        chk("postrst_inflight", int'(inflight), 1);
        cyc(0, 0, 1, 1, 0);

`ifdef BHT_GSHARE_EN
        do_reset();
        cyc(1, 32'h40, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(1, 32'h40, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(1, 32'h40, 0, 0, 0);
        chk("gshare_taken", int'(pred_out_taken), 0);
        cyc(0, 0, 1, 0, 0);
`endif

        cyc(0, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
